// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker_pkg: shared state encoding for the counter sequence checker.
package count_seq_checker_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;
  always_comb begin
    value_d = clear ? '0 : (inc && value_q != '1) ? value_q + W'(1) : value_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= '0;
    else value_q <= value_d;
  end
  assign value = value_q;
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: tracks the expected count of a free-running counter and
// compares it with the observed value every cycle, reporting pass/fail per run.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ERR_W       = 8,
  parameter int CHK_W       = 16,
  parameter int CHECK_LEN   = 382,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cnt_rst,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [CHK_W-1:0] checks,
  output logic [WIDTH-1:0] exp_out,
  output logic [WIDTH-1:0] first_bad
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d, first_bad_q, first_bad_d;
  logic error_q, error_d, pass_q, pass_d, done_q, done_d;
  logic run, begin_run, mismatch, last_chk, end_run;
  logic [CHK_W-1:0] checks_v;
  logic [ERR_W-1:0] err_v;
  assign run       = state_q == RUN;
  assign begin_run = start && !run;
  assign mismatch  = run && cnt_in != exp_q;
  // Compare against the post-increment check count so the run ends on the edge that reaches CHECK_LEN
  assign last_chk  = CHECK_LEN != 0 && ({1'b0, checks_v} + (CHK_W+1)'(1)) == (CHK_W+1)'(CHECK_LEN);
  assign end_run   = run && (last_chk || (STOP_ON_ERR != 0 && mismatch));
  always_comb begin
    state_d     = begin_run ? RUN : end_run ? DONE : state_q;
    exp_d       = begin_run ? '0 : run ? (cnt_rst ? '0 : exp_q + WIDTH'(1)) : exp_q;
    error_d     = !begin_run && (error_q || mismatch);
    first_bad_d = begin_run ? '0 : (mismatch && !error_q) ? cnt_in : first_bad_q;
    pass_d      = begin_run ? 1'b0 : end_run ? !(error_q || mismatch) : pass_q;
    done_d      = end_run;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      error_q     <= 1'b0;
      first_bad_q <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      error_q     <= error_d;
      first_bad_q <= first_bad_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
    end
  end
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .reset_n(reset_n), .clear(begin_run), .inc(mismatch), .value(err_v)
  );
  sat_counter #(.W(CHK_W)) u_chk (
    .clk(clk), .reset_n(reset_n), .clear(begin_run), .inc(run), .value(checks_v)
  );
  assign busy      = run;
  assign done      = done_q;
  assign pass      = pass_q;
  assign error     = error_q;
  assign err_count = err_v;
  assign checks    = checks_v;
  assign exp_out   = exp_q;
  assign first_bad = first_bad_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: three checker configurations share one stimulus stream
// and are compared every cycle against a run-level reference model.
module tb_count_seq_checker;
  logic clk = 1'b0, reset_n, start, cnt_rst;
  logic [7:0] cnt_in;
  logic       busy_a, done_a, pass_a, error_a, busy_b, done_b, pass_b, error_b, busy_c, done_c, pass_c, error_c;
  logic [7:0] errc_a, errc_c, exp_a, exp_b, exp_c, fb_a, fb_b, fb_c;
  logic [1:0] errc_b;
  logic [15:0] chk_a, chk_b, chk_c;
  int n_chk = 0, n_fail = 0, ctr = 0;
  localparam int LEN[3]    = '{266, 0, 300};
  localparam int ERRMAX[3] = '{255, 3, 255};
  localparam int STOP[3]   = '{0, 0, 1};
  bit running[3], finished[3], m_done[3], m_err[3], m_pass[3];
  int m_exp[3], m_errs[3], m_chks[3], m_fb[3];

  always #5 clk = ~clk;

  count_seq_checker #(.CHECK_LEN(266)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .cnt_rst(cnt_rst), .cnt_in(cnt_in),
    .busy(busy_a), .done(done_a), .pass(pass_a), .error(error_a), .err_count(errc_a),
    .checks(chk_a), .exp_out(exp_a), .first_bad(fb_a));
  count_seq_checker #(.ERR_W(2), .CHECK_LEN(0)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .cnt_rst(cnt_rst), .cnt_in(cnt_in),
    .busy(busy_b), .done(done_b), .pass(pass_b), .error(error_b), .err_count(errc_b),
    .checks(chk_b), .exp_out(exp_b), .first_bad(fb_b));
  count_seq_checker #(.CHECK_LEN(300), .STOP_ON_ERR(1)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start), .cnt_rst(cnt_rst), .cnt_in(cnt_in),
    .busy(busy_c), .done(done_c), .pass(pass_c), .error(error_c), .err_count(errc_c),
    .checks(chk_c), .exp_out(exp_c), .first_bad(fb_c));

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      running[i] = 0; finished[i] = 0; m_done[i] = 0; m_err[i] = 0; m_pass[i] = 0;
      m_exp[i] = 0; m_errs[i] = 0; m_chks[i] = 0; m_fb[i] = 0;
    end
  endtask

  // One clock edge of each checker, stated as run-level rules on integers.
  task automatic model_step();
    bit mis;
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0;
      if (running[i]) begin
        mis = int'(cnt_in) != m_exp[i];
        if (m_chks[i] < 65535) m_chks[i]++;
        if (mis) begin
          if (m_errs[i] < ERRMAX[i]) m_errs[i]++;
          if (!m_err[i]) m_fb[i] = int'(cnt_in);
          m_err[i] = 1;
        end
        m_exp[i] = cnt_rst ? 0 : (m_exp[i] + 1) % 256;
        if ((LEN[i] != 0 && m_chks[i] == LEN[i]) || (STOP[i] != 0 && mis)) begin
          running[i] = 0; finished[i] = 1; m_done[i] = 1; m_pass[i] = !m_err[i];
        end
      end else if (start) begin
        running[i] = 1; finished[i] = 0; m_err[i] = 0; m_errs[i] = 0;
        m_chks[i] = 0; m_fb[i] = 0; m_pass[i] = 0; m_exp[i] = 0;
      end
    end
  endtask

  task automatic check_dut(int i, logic b, logic d, logic p, logic e, logic [7:0] ec,
                           logic [15:0] ch, logic [7:0] ex, logic [7:0] fb);
    check($sformatf("u%0d.busy", i), 32'(b), 32'(running[i]));
    check($sformatf("u%0d.done", i), 32'(d), 32'(m_done[i]));
    check($sformatf("u%0d.pass", i), 32'(p), 32'(m_pass[i]));
    check($sformatf("u%0d.error", i), 32'(e), 32'(m_err[i]));
    check($sformatf("u%0d.err_count", i), 32'(ec), m_errs[i]);
    check($sformatf("u%0d.checks", i), 32'(ch), m_chks[i]);
    check($sformatf("u%0d.exp_out", i), 32'(ex), m_exp[i]);
    check($sformatf("u%0d.first_bad", i), 32'(fb), m_fb[i]);
  endtask

  task automatic check_all();
    check_dut(0, busy_a, done_a, pass_a, error_a, errc_a, chk_a, exp_a, fb_a);
    check_dut(1, busy_b, done_b, pass_b, error_b, {6'b0, errc_b}, chk_b, exp_b, fb_b);
    check_dut(2, busy_c, done_c, pass_c, error_c, errc_c, chk_c, exp_c, fb_c);
  endtask

  // v < 0 drives the true count of the counter under test; otherwise v itself.
  task automatic drive(bit st, bit cr, int v);
    start = st;
    cnt_rst = cr;
    cnt_in = v < 0 ? 8'(ctr) : 8'(v);
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    ctr = cnt_rst ? 0 : (ctr + 1) % 256;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_random(int n);
    bit st, cr, bad;
    for (int k = 0; k < n; k++) begin
      st  = $urandom_range(0, 59) == 0;
      cr  = st || $urandom_range(0, 39) == 0;
      bad = $urandom_range(0, 49) == 0;
      drive(st, cr, bad ? (ctr ^ int'($urandom_range(1, 255))) : -1);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; cnt_rst = 1'b0; cnt_in = '0;
    model_reset();
    #3 check_all();
    @(negedge clk) reset_n = 1'b1;
    repeat (3) drive(0, 0, -1);
    drive(1, 1, -1);
    repeat (280) drive(0, 0, -1);
    drive(1, 1, -1);
    repeat (10) drive(0, 0, -1);
    drive(0, 0, 'h55);
    repeat (5) drive(0, 0, -1);
    drive(0, 0, 'hAA);
    repeat (10) drive(0, 0, 'hFF);
    repeat (300) drive(0, 0, -1);
    drive(1, 1, -1);
    repeat (126) drive(0, 0, -1);
    drive(0, 1, -1);
    repeat (200) drive(0, 0, -1);
    run_random(1500);
    drive(1, 1, -1);
    repeat (20) drive(0, 0, -1);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 reset_n = 1'b1;
    @(negedge clk);
    drive(1, 1, -1);
    run_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Hardware sequence checker that consumes the output of a free-running up-counter benchmark, such as the 8-bit counter mapped onto the fabric. It keeps its own reference model of the count and compares it with the observed value every clock. It accumulates mismatch statistics and reports pass/fail after a programmed number of checks. This lets counter benchmarks self-check on silicon or in gate-level simulation without a behavioural testbench model.

Parameters:
WIDTH, 8, width of the observed counter value
ERR_W, 8, width of the saturating mismatch counter
CHK_W, 16, width of the check counter
CHECK_LEN, 382, number of checks per run; 0 = free-running, never completes
STOP_ON_ERR, 0, 1 = end the run on the first mismatch

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a run from IDLE or DONE
cnt_rst  input  1  the reset driven to the counter under test (synchronous, active-high)
cnt_in  input  WIDTH  observed counter value
busy  output  1  high in RUN
done  output  1  one-cycle pulse on entering DONE
pass  output  1  valid in DONE: 1 = no mismatch during the run
error  output  1  sticky, set on the first mismatch of the run
err_count  output  ERR_W  saturating number of mismatches
checks  output  CHK_W  number of comparisons performed this run
exp_out  output  WIDTH  current expected value
first_bad  output  WIDTH  cnt_in captured at the first mismatch

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-run): state IDLE; all outputs 0; exp = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 -> RUN. Same edge: clear error, err_count, checks, first_bad and pass; exp <= 0.
- RUN, every rising edge:
  - compare cnt_in with the current exp, using the pre-update value;
  - mismatch -> err_count += 1, saturating at 2^ERR_W-1; error <= 1;
  - first_bad <= cnt_in on the first mismatch of the run only;
  - checks += 1, saturating;
  - exp <= cnt_rst ? 0 : exp+1 mod 2^WIDTH (255 -> 0 for WIDTH=8).
- cnt_rst and a compare in the same cycle: the compare still uses the old exp. This matches a counter that is cleared on that edge.
- End of run, RUN -> DONE, when either:
  - CHECK_LEN != 0 and this edge makes checks == CHECK_LEN; or
  - STOP_ON_ERR=1 and this edge detects a mismatch.
- Entering DONE: done=1 for exactly one cycle. pass = NOT(error including this edge's compare), held until the next start or reset.
- start in RUN: ignored. start in DONE: same behaviour as from IDLE.
- Latency: all status outputs reflect a compare on the cycle after the sampling edge (registered outputs).
- CHECK_LEN=0: stays in RUN indefinitely; done never asserts; pass stays 0.
- busy = (state == RUN). exp_out is registered exp.

Decomposition:
- Package count_seq_checker_pkg: state enum (IDLE/RUN/DONE) and the state-width constant.
- Sub-module sat_counter (parameter W; ports clear, inc, value). Instantiated for err_count and checks.

Test Plan:
- Clean run. CHECK_LEN=255; start, drive 0..254 one per cycle. Required: done pulse one cycle after the edge sampling 254; pass=1; err_count=0; checks=255; error=0.
- Wrap. CHECK_LEN=266; drive 0..255 then 0..9. Required: pass=1; exp_out passes 255 -> 0 with no error.
- Mid-run counter reset. Drive 0..126; on the cycle with cnt_in=127 hold cnt_rst=1; next cycles drive 0,1,2... Required: no mismatch; exp_out=0 after that edge; pass=1 at done.
- Single corruption. Drive 0x55 instead of 10 at check 10. Required: error=1 and err_count=1 on the following cycle; first_bad=0x55; later mismatches leave first_bad unchanged; pass=0 at done.
- Saturation. ERR_W=2; drive constant 0xFF for 10 cycles. Required: err_count reaches 3 and holds 3.
- STOP_ON_ERR=1. Mismatch at the 6th check. Required: done on the next cycle; checks=6; pass=0; busy=0.
- Async reset. Pull reset_n low mid-run between edges. Required: all outputs 0 immediately.
